// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: serial line, runtime frame mode,
// and the valid/ready frame handshake with its status flags.
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  rx;
    logic [1:0]            parity_mode;
    logic                  two_stop;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid;
    logic                  ready;
    logic                  parity_err;
    logic                  frame_err;
    logic                  break_det;
    logic                  overrun;
    logic                  busy;

    modport master (
        input  rx, parity_mode, two_stop, ready,
        output data_out, valid, parity_err, frame_err,
        output break_det, overrun, busy
    );

    modport slave (
        output rx, parity_mode, two_stop, ready,
        input  data_out, valid, parity_err, frame_err,
        input  break_det, overrun, busy
    );
endinterface

// File: rtl/uart_rx_engine.sv
// Oversampling UART receiver with majority vote, runtime parity and
// stop-bit mode, error/break flags and a single-slot output register.
module uart_rx_engine #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic      clock,
    input  logic      reset_n,
    uart_rx_if.master bus
);
    localparam int CLKS_PER_SAMPLE = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int MID = OVERSAMPLE / 2 - 1;
    localparam int CW  = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_WIDTH);

    if (CLKS_PER_SAMPLE < 2) begin : g_bad_rate
        $error("uart_rx_engine: CLKS_PER_SAMPLE must be >= 2");
    end
    if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
        $error("uart_rx_engine: DATA_WIDTH must be 5..9");
    end
    if (OVERSAMPLE != 8 && OVERSAMPLE != 16) begin : g_bad_os
        $error("uart_rx_engine: OVERSAMPLE must be 8 or 16");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e                state_q, state_d;
    logic                  rx_meta_q, rx_s_q, rx_prev_q;
    logic [CW-1:0]         clk_cnt_q, clk_cnt_d;
    logic [SW-1:0]         smp_cnt_q, smp_cnt_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  stop_idx_q, stop_idx_d;
    logic [1:0]            votes_q, votes_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [1:0]            pmode_q, pmode_d;
    logic                  two_q, two_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic                  pbit_q, pbit_d;
    logic                  stop0_q, stop0_d;

    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  valid_q, valid_d;
    logic                  perr_o_q, perr_o_d;
    logic                  ferr_o_q, ferr_o_d;
    logic                  brk_q, brk_d;
    logic                  ovr_q, ovr_d;

    logic tick, fall, smp_last, wrap, vote_now, bit_v, par_en;
    logic done, fe_now, stop_first, brk_now;

    assign tick     = (clk_cnt_q == CW'(CLKS_PER_SAMPLE - 1));
    assign fall     = rx_prev_q & ~rx_s_q;
    assign smp_last = (smp_cnt_q == SW'(OVERSAMPLE - 1));
    assign wrap     = tick & smp_last;
    assign vote_now = tick & (smp_cnt_q == SW'(MID + 1));
    assign par_en   = (pmode_q == 2'b01) | (pmode_q == 2'b10);

    // Third sample is taken live on the resolving tick
    assign bit_v = (votes_q[0] & votes_q[1]) |
                   (votes_q[0] & rx_s_q) |
                   (votes_q[1] & rx_s_q);

    assign fe_now     = ferr_q | ~bit_v;
    assign stop_first = stop_idx_q ? stop0_q : bit_v;
    assign brk_now    = (shift_q == '0) & (~par_en | ~pbit_q) & ~stop_first;

    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        smp_cnt_d  = smp_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        stop_idx_d = stop_idx_q;
        votes_d    = votes_q;
        shift_d    = shift_q;
        pmode_d    = pmode_q;
        two_d      = two_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        pbit_d     = pbit_q;
        stop0_d    = stop0_q;
        done       = 1'b0;

        if (tick) begin
            clk_cnt_d = '0;
            smp_cnt_d = smp_last ? '0 : smp_cnt_q + 1'b1;
        end else begin
            clk_cnt_d = clk_cnt_q + 1'b1;
        end
        if (tick && smp_cnt_q == SW'(MID - 1)) votes_d[0] = rx_s_q;
        if (tick && smp_cnt_q == SW'(MID)) votes_d[1] = rx_s_q;

        unique case (state_q)
            S_IDLE: begin
                if (fall) begin
                    state_d    = S_START;
                    pmode_d    = bus.parity_mode;
                    two_d      = bus.two_stop;
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
                    pbit_d     = 1'b0;
                    bit_cnt_d  = '0;
                    stop_idx_d = 1'b0;
                end
            end
            S_START: begin
                if (vote_now && bit_v) state_d = S_IDLE;
                else if (wrap) state_d = S_DATA;
            end
            S_DATA: begin
                if (vote_now) shift_d = {bit_v, shift_q[DATA_WIDTH-1:1]};
                if (wrap) begin
                    if (bit_cnt_q == BW'(DATA_WIDTH - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = par_en ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (vote_now) begin
                    pbit_d = bit_v;
                    perr_d = ((^shift_q) ^ bit_v) != (pmode_q == 2'b10);
                end
                if (wrap) state_d = S_STOP;
            end
            S_STOP: begin
                if (vote_now) begin
                    if (!bit_v) ferr_d = 1'b1;
                    if (!stop_idx_q) stop0_d = bit_v;
                    // Finish mid-bit so the next start edge is not missed
                    if (stop_idx_q == two_q) begin
                        done    = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                if (wrap && !done) stop_idx_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q == S_IDLE || state_d == S_IDLE) begin
            clk_cnt_d = '0;
            smp_cnt_d = '0;
        end
    end

    always_comb begin
        dout_d   = dout_q;
        perr_o_d = perr_o_q;
        ferr_o_d = ferr_o_q;
        brk_d    = brk_q;
        ovr_d    = 1'b0;
        valid_d  = valid_q & ~bus.ready;
        if (done) begin
            if (!valid_q || bus.ready) begin
                dout_d   = shift_q;
                perr_o_d = perr_q;
                ferr_o_d = fe_now;
                brk_d    = brk_now;
                valid_d  = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_prev_q  <= 1'b1;
            clk_cnt_q  <= '0;
            smp_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            stop_idx_q <= 1'b0;
            votes_q    <= '0;
            shift_q    <= '0;
            pmode_q    <= '0;
            two_q      <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            pbit_q     <= 1'b0;
            stop0_q    <= 1'b0;
            dout_q     <= '0;
            valid_q    <= 1'b0;
            perr_o_q   <= 1'b0;
            ferr_o_q   <= 1'b0;
            brk_q      <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_meta_q  <= bus.rx;
            rx_s_q     <= rx_meta_q;
            rx_prev_q  <= rx_s_q;
            clk_cnt_q  <= clk_cnt_d;
            smp_cnt_q  <= smp_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_idx_q <= stop_idx_d;
            votes_q    <= votes_d;
            shift_q    <= shift_d;
            pmode_q    <= pmode_d;
            two_q      <= two_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            pbit_q     <= pbit_d;
            stop0_q    <= stop0_d;
            dout_q     <= dout_d;
            valid_q    <= valid_d;
            perr_o_q   <= perr_o_d;
            ferr_o_q   <= ferr_o_d;
            brk_q      <= brk_d;
            ovr_q      <= ovr_d;
        end
    end

    assign bus.data_out   = dout_q;
    assign bus.valid      = valid_q;
    assign bus.parity_err = perr_o_q;
    assign bus.frame_err  = ferr_o_q;
    assign bus.break_det  = brk_q;
    assign bus.overrun    = ovr_q;
    assign bus.busy       = (state_q != S_IDLE);
endmodule

// File: doc/uart_rx_engine.md
Name: uart_rx_engine

Overview:
- Self-contained, parametrised UART receiver: integrated FSM, oversampling counters, 3-sample majority vote, runtime parity/stop-bit mode, error flags.
- Delivers each frame over a valid/ready output handshake, with overrun and break reporting.
- Sits between the board RX pin and the byte-stream consumer; replaces the externally sequenced RX datapath + FSM pair.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD_RATE, 115200, line rate in bit/s.
- DATA_WIDTH, 8, data bits per frame; legal 5..9.
- OVERSAMPLE, 16, sample ticks per bit; legal 8 or 16.
- Derived CLKS_PER_SAMPLE = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), must be >= 2 (elaboration error otherwise).
- Derived MID = OVERSAMPLE/2 - 1.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- rx  in  1  asynchronous serial line; idles high.
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none; sampled at start-bit detect.
- two_stop  in  1  0 = 1 stop bit, 1 = 2 stop bits; sampled at start-bit detect.
- data_out  out  DATA_WIDTH  received word, LSB = first bit on the wire.
- valid  out  1  frame available.
- ready  in  1  consumer accepts when valid & ready.
- parity_err  out  1  parity mismatch for the presented frame.
- frame_err  out  1  a stop bit voted 0 for the presented frame.
- break_det  out  1  all data bits 0, parity bit (if enabled) 0, and first stop bit 0.
- overrun  out  1  one-cycle pulse when a completed frame is dropped.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (reset_n=0 at a clock edge): state IDLE; all counters 0; 2-FF synchroniser and edge register set to 1; data_out=0; valid, parity_err, frame_err, break_det, overrun, busy = 0. A reset asserted mid-frame aborts the frame and produces no output.
- Input conditioning: rx passes through a 2-FF synchroniser (rx_s). Falling edge = previous rx_s 1, current rx_s 0.
- Sample tick: clk_count counts 0..CLKS_PER_SAMPLE-1 and wraps. tick = (clk_count == CLKS_PER_SAMPLE-1). Counters are held cleared in IDLE.
- Within a bit, sample_count advances 0..OVERSAMPLE-1 on each tick and wraps. Wrap advances the bit position.
- Majority vote: rx_s is captured on ticks with sample_count = MID-1, MID, MID+1. Bit value = majority of the 3. The value is resolved on the MID+1 tick.
- State IDLE: on falling edge, latch parity_mode and two_stop, clear counters, go to START.
- State START: at vote resolution, 1 -> false start, return to IDLE with no output; 0 -> go to DATA when sample_count wraps.
- State DATA: each voted bit shifts into the SIPO, LSB first. After DATA_WIDTH bits, go to PARITY if parity is enabled, else STOP.
- State PARITY: voted bit is checked against the data. Even: XOR(data, bit) must be 0. Odd: it must be 1. Mismatch sets a pending parity error.
- State STOP: voted 0 sets a pending frame error. With two_stop, a second STOP bit is sampled the same way.
- Frame completion occurs at the vote resolution of the final stop bit, not at bit end, so the next start edge is detectable early. The FSM returns to IDLE on that cycle.
- Output register loads on the cycle after frame completion when the slot is free: the slot is free if valid=0, or valid & ready in the completion cycle. On load: data_out and the three error flags are updated and valid=1.
- If the slot is not free at completion, the new frame is dropped, overrun pulses 1 cycle, and data_out/flags hold their values.
- Handshake: valid & ready at an edge -> valid=0 next cycle unless a new frame loads in that same cycle (then valid stays 1 with the new data). data_out and flags are stable while valid=1 and ready=0. ready is ignored while valid=0.
- busy = (state != IDLE).

Test Plan:
- Config for all scenarios: CLK_FREQ=100_000_000, BAUD_RATE=1_562_500, OVERSAMPLE=16 -> 4 clk/sample, 64 clk/bit. DATA_WIDTH=8.
- 8N1 frame 0xA5, ready=1 -> valid pulses 1 cycle with data_out=0xA5, all error flags 0. valid rises 9*64+9*4 clk (±4) after the rx falling edge.
- 8E1 frame 0x03 with parity bit 1 -> data_out=0x03, parity_err=1. Same frame with parity 0 -> parity_err=0. 8O1 with parity 1 -> parity_err=0.
- 8N2 frame 0x5A, second stop bit driven 0 -> frame_err=1. Line held low for 12 bit times -> break_det=1, frame_err=1, data_out=0x00; no new frame until rx returns high and falls again.
- rx low glitch of 20 clk in IDLE -> false start, valid stays 0, busy returns to 0 within one bit time. Single 4-clk glitch inside a data bit window -> majority vote recovers the correct byte.
- ready=0, two back-to-back frames 0x11, 0x22 -> data_out holds 0x11, overrun pulses once at the end of frame 2. Raising ready then accepts 0x11 and valid falls.
- reset_n=0 for one cycle at data bit 4 of a frame -> valid, busy = 0. Next complete frame 0x3C is received correctly.
